// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the general-purpose register file.
package regfile_pkg;

   typedef enum logic {IDLE, CLEAR} rf_state_t;

   localparam int RF_DATA_W_DFLT = 8;
   localparam int RF_DEPTH_DFLT  = 8;

endpackage

// File: rtl/regfile_word.sv
// One storage word of the register file: sync reset, load enable and sync clear.
module regfile_word
   import regfile_pkg::*;
#(
   parameter int DATA_W = RF_DATA_W_DFLT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic              clear_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] data_o
);

   logic [DATA_W-1:0] word_q;
   logic [DATA_W-1:0] word_d;

   // Clear wins over load so a sweep always leaves the word at zero.
   always_comb begin
      word_d = word_q;
      if (clear_i) begin
         word_d = '0;
      end else if (load_i) begin
         word_d = data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         word_q <= '0;
      end else begin
         word_q <= word_d;
      end
   end

   assign data_o = word_q;

endmodule

// File: rtl/regfile_param.sv
// DEPTH x DATA_W register file, word 0 hardwired to zero, with a sequential bulk-clear engine.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_param
   import regfile_pkg::*;
#(
   parameter int DATA_W = RF_DATA_W_DFLT,
   parameter int DEPTH  = RF_DEPTH_DFLT,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int NUM_RD = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   output logic                     wr_ready,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   input  logic                     clear_req,
   output logic                     busy,
   output logic                     clear_done
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   rf_state_t         state_q;
   rf_state_t         state_d;
   logic [ADDR_W-1:0] ptr_q;
   logic [ADDR_W-1:0] ptr_d;
   logic              wr_accept;
   logic [ADDR_W-1:0] rd_idx;
   logic [DATA_W-1:0] mem [1:DEPTH-1];

   assign busy      = (state_q == CLEAR);
   assign wr_ready  = !busy;
   assign wr_accept = wr_en && wr_ready && (wr_addr != '0) && (int'(wr_addr) < DEPTH);

   // Word 0 has no storage; every other word is its own register.
   for (genvar w = 1; w < DEPTH; w++) begin : g_word
      regfile_word #(.DATA_W(DATA_W)) u_word (
         .clk     (clk),
         .rst     (rst),
         .load_i  (wr_accept && (wr_addr == ADDR_W'(w))),
         .clear_i (busy && (ptr_q == ADDR_W'(w))),
         .data_i  (wr_data),
         .data_o  (mem[w])
      );
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      clear_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (clear_req) begin
               state_d = CLEAR;
               ptr_d   = ADDR_W'(1);
            end
         end
         CLEAR: begin
            if (ptr_q == LAST_ADDR) begin
               clear_done = 1'b1;
               state_d    = IDLE;
               ptr_d      = '0;
            end else begin
               ptr_d = ptr_q + ADDR_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // Addresses 0 and >= DEPTH match no stored word and so read as zero.
   always_comb begin
      rd_data = '0;
      rd_idx  = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         rd_idx = rd_addr[p*ADDR_W +: ADDR_W];
         for (int w = 1; w < DEPTH; w++) begin
            if (rd_idx == ADDR_W'(w)) begin
               rd_data[p*DATA_W +: DATA_W] = mem[w];
            end
         end
`ifdef REGFILE_BYPASS_EN
         if (wr_accept && (wr_addr == rd_idx)) begin
            rd_data[p*DATA_W +: DATA_W] = wr_data;
         end
`endif
      end
   end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: a DEPTH=8 and a DEPTH=6 instance against an array model.
module tb_regfile_param;

   localparam int DW = 8;
   localparam int AW = 3;
   localparam int NR = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [1:0]        wrEn;
   logic [1:0]        clearReq;
   logic [AW-1:0]     wrAddr [2];
   logic [DW-1:0]     wrData [2];
   logic [NR*AW-1:0]  rdAddr [2];
   logic [NR*DW-1:0]  rdData [2];
   logic [1:0]        wrReady;
   logic [1:0]        busy;
   logic [1:0]        clearDone;

   int checks   = 0;
   int failures = 0;

   logic [7:0] model [2][8];
   int depthOf [2] = '{8, 6};
   int clrLeft [2];
   int clrPtr  [2];

   always #5 clk = ~clk;

   regfile_param #(.DATA_W(DW), .DEPTH(8), .NUM_RD(NR)) dut8 (
      .clk(clk), .rst(rst), .wr_en(wrEn[0]), .wr_addr(wrAddr[0]), .wr_data(wrData[0]),
      .wr_ready(wrReady[0]), .rd_addr(rdAddr[0]), .rd_data(rdData[0]),
      .clear_req(clearReq[0]), .busy(busy[0]), .clear_done(clearDone[0])
   );

   regfile_param #(.DATA_W(DW), .DEPTH(6), .NUM_RD(NR)) dut6 (
      .clk(clk), .rst(rst), .wr_en(wrEn[1]), .wr_addr(wrAddr[1]), .wr_data(wrData[1]),
      .wr_ready(wrReady[1]), .rd_addr(rdAddr[1]), .rd_data(rdData[1]),
      .clear_req(clearReq[1]), .busy(busy[1]), .clear_done(clearDone[1])
   );

   // Reference behaviour of one clock edge: reset, else one word of an ongoing sweep, else write/clear start.
   function automatic void modelStep(int k);
      if (rst) begin
         for (int a = 0; a < 8; a++) model[k][a] = 8'h00;
         clrLeft[k] = 0;
      end else if (clrLeft[k] > 0) begin
         model[k][clrPtr[k]] = 8'h00;
         clrPtr[k]++;
         clrLeft[k]--;
      end else begin
         if (wrEn[k] && wrAddr[k] != 0 && int'(wrAddr[k]) < depthOf[k]) model[k][wrAddr[k]] = wrData[k];
         if (clearReq[k]) begin
            clrLeft[k] = depthOf[k] - 1;
            clrPtr[k]  = 1;
         end
      end
   endfunction

   function automatic logic [7:0] expRead(int k, logic [AW-1:0] a);
      logic [7:0] v;
      if (a == 0 || int'(a) >= depthOf[k]) return 8'h00;
      v = model[k][a];
`ifdef REGFILE_BYPASS_EN
      if (wrEn[k] && clrLeft[k] == 0 && wrAddr[k] == a) v = wrData[k];
`endif
      return v;
   endfunction

   task automatic tick();
      for (int k = 0; k < 2; k++) modelStep(k);
      @(posedge clk);
      #1;
   endtask

   task automatic idleInputs();
      rst      = 1'b0;
      wrEn     = '0;
      clearReq = '0;
      for (int k = 0; k < 2; k++) begin
         wrAddr[k] = '0;
         wrData[k] = '0;
         rdAddr[k] = '0;
      end
   endtask

   task automatic setRd(int k, int p, logic [AW-1:0] a);
      rdAddr[k][p*AW +: AW] = a;
   endtask

   task automatic writeWord(int k, logic [AW-1:0] a, logic [7:0] d);
      wrEn[k]   = 1'b1;
      wrAddr[k] = a;
      wrData[k] = d;
      tick();
      wrEn[k]   = 1'b0;
   endtask

   task automatic test_reset();
      idleInputs();
      rst = 1'b1;
      wrEn[0] = 1'b1; wrAddr[0] = 3'd4; wrData[0] = 8'hC3;
      tick();
      idleInputs();
      #1;
      checks++;
      if (busy !== 2'b00) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=00", busy); end
      checks++;
      if (wrReady !== 2'b11) begin failures++; $display("[TB] FAIL reset_wr_ready got=%b exp=11", wrReady); end
      checks++;
      if (clearDone !== 2'b00) begin failures++; $display("[TB] FAIL reset_clear_done got=%b exp=00", clearDone); end
      for (int a = 0; a < 4; a++) begin
         setRd(0, 0, AW'(a));
         setRd(0, 1, AW'(a + 4));
         #1;
         checks++;
         if (rdData[0] !== 16'h0000) begin failures++; $display("[TB] FAIL reset_words addr=%0d/%0d got=%h exp=0000", a, a + 4, rdData[0]); end
      end
   endtask

   task automatic test_write_read();
      idleInputs();
      writeWord(0, 3'd3, 8'hA5);
      setRd(0, 0, 3'd3);
      setRd(0, 1, 3'd0);
      #1;
      checks++;
      if (rdData[0][7:0] !== 8'hA5) begin failures++; $display("[TB] FAIL write_read_addr3 got=%h exp=a5", rdData[0][7:0]); end
      checks++;
      if (rdData[0][15:8] !== 8'h00) begin failures++; $display("[TB] FAIL write_read_addr0 got=%h exp=00", rdData[0][15:8]); end
   endtask

   task automatic test_addr_zero();
      idleInputs();
      wrEn[0] = 1'b1; wrAddr[0] = 3'd0; wrData[0] = 8'hFF;
      setRd(0, 0, 3'd0);
      #1;
      checks++;
      if (wrReady[0] !== 1'b1) begin failures++; $display("[TB] FAIL addr0_wr_ready got=%b exp=1", wrReady[0]); end
      checks++;
      if (rdData[0][7:0] !== 8'h00) begin failures++; $display("[TB] FAIL addr0_same_cycle got=%h exp=00", rdData[0][7:0]); end
      tick();
      wrEn[0] = 1'b0;
      #1;
      checks++;
      if (rdData[0][7:0] !== 8'h00) begin failures++; $display("[TB] FAIL addr0_after got=%h exp=00", rdData[0][7:0]); end
   endtask

   task automatic test_bulk_clear();
      idleInputs();
      for (int a = 1; a < 8; a++) writeWord(0, AW'(a), 8'(8'h11 * a));
      clearReq[0] = 1'b1;
      tick();
      clearReq[0] = 1'b0;
      for (int i = 0; i < 7; i++) begin
         wrEn[0] = 1'b1; wrAddr[0] = 3'd4; wrData[0] = 8'hEE;
         setRd(0, 0, 3'd7);
         setRd(0, 1, AW'(i));
         #1;
         checks++;
         if (busy[0] !== 1'b1 || wrReady[0] !== 1'b0) begin
            failures++; $display("[TB] FAIL clear_busy cycle=%0d got busy=%b ready=%b exp busy=1 ready=0", i + 1, busy[0], wrReady[0]);
         end
         checks++;
         if (clearDone[0] !== (i == 6)) begin failures++; $display("[TB] FAIL clear_done cycle=%0d got=%b exp=%b", i + 1, clearDone[0], i == 6); end
         checks++;
         if (rdData[0] !== {8'h00, 8'h77}) begin failures++; $display("[TB] FAIL clear_partial cycle=%0d got=%h exp=0077", i + 1, rdData[0]); end
         tick();
      end
      wrEn[0] = 1'b0;
      #1;
      checks++;
      if (busy[0] !== 1'b0 || wrReady[0] !== 1'b1) begin failures++; $display("[TB] FAIL clear_end got busy=%b ready=%b exp busy=0 ready=1", busy[0], wrReady[0]); end
      for (int a = 0; a < 4; a++) begin
         setRd(0, 0, AW'(a));
         setRd(0, 1, AW'(a + 4));
         #1;
         checks++;
         if (rdData[0] !== 16'h0000) begin failures++; $display("[TB] FAIL clear_result addr=%0d/%0d got=%h exp=0000", a, a + 4, rdData[0]); end
      end
   endtask

   task automatic test_clear_with_write();
      int n;
      idleInputs();
      clearReq[0] = 1'b1;
      wrEn[0] = 1'b1; wrAddr[0] = 3'd2; wrData[0] = 8'h5A;
      tick();
      idleInputs();
      setRd(0, 0, 3'd2);
      #1;
      checks++;
      if (rdData[0][7:0] !== 8'h5A) begin failures++; $display("[TB] FAIL clrwr_landed got=%h exp=5a", rdData[0][7:0]); end
      n = 0;
      while (clearDone[0] !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (n >= 20) begin failures++; $display("[TB] FAIL clrwr_timeout got cycles=%0d exp<20", n); end
      tick();
      checks++;
      if (rdData[0][7:0] !== 8'h00 || busy[0] !== 1'b0) begin
         failures++; $display("[TB] FAIL clrwr_erased got data=%h busy=%b exp data=00 busy=0", rdData[0][7:0], busy[0]);
      end
   endtask

   task automatic test_reset_mid_clear();
      idleInputs();
      for (int a = 1; a < 8; a++) writeWord(0, AW'(a), 8'($urandom_range(1, 255)));
      clearReq[0] = 1'b1;
      tick();
      clearReq[0] = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      checks++;
      if (busy[0] !== 1'b1 || clearDone[0] !== 1'b0) begin
         failures++; $display("[TB] FAIL midrst_before got busy=%b done=%b exp busy=1 done=0", busy[0], clearDone[0]);
      end
      tick();
      rst = 1'b0;
      checks++;
      if (busy[0] !== 1'b0 || wrReady[0] !== 1'b1) begin
         failures++; $display("[TB] FAIL midrst_after got busy=%b ready=%b exp busy=0 ready=1", busy[0], wrReady[0]);
      end
      for (int c = 0; c < 8; c++) begin
         checks++;
         if (clearDone[0] !== 1'b0) begin failures++; $display("[TB] FAIL midrst_no_done cycle=%0d got=%b exp=0", c, clearDone[0]); end
         tick();
      end
      for (int a = 0; a < 4; a++) begin
         setRd(0, 0, AW'(a));
         setRd(0, 1, AW'(a + 4));
         #1;
         checks++;
         if (rdData[0] !== 16'h0000) begin failures++; $display("[TB] FAIL midrst_words addr=%0d/%0d got=%h exp=0000", a, a + 4, rdData[0]); end
      end
   endtask

   task automatic test_back_to_back();
      idleInputs();
      clearReq[0] = 1'b1;
      for (int t = 1; t <= 16; t++) begin
         tick();
         checks++;
         if (busy[0] !== ((t % 8) != 0) || clearDone[0] !== ((t % 8) == 7)) begin
            failures++;
            $display("[TB] FAIL b2b_clear t=%0d got busy=%b done=%b exp busy=%b done=%b", t, busy[0], clearDone[0], (t % 8) != 0, (t % 8) == 7);
         end
      end
      clearReq[0] = 1'b0;
      tick();
   endtask

   task automatic test_bypass();
      idleInputs();
      writeWord(0, 3'd5, 8'h21);
      writeWord(0, 3'd6, 8'h62);
      wrEn[0] = 1'b1; wrAddr[0] = 3'd5; wrData[0] = 8'h3C;
      setRd(0, 0, 3'd5);
      setRd(0, 1, 3'd6);
      #1;
      checks++;
`ifdef REGFILE_BYPASS_EN
      if (rdData[0][7:0] !== 8'h3C) begin failures++; $display("[TB] FAIL bypass_same_cycle got=%h exp=3c", rdData[0][7:0]); end
`else
      if (rdData[0][7:0] !== 8'h21) begin failures++; $display("[TB] FAIL bypass_same_cycle got=%h exp=21", rdData[0][7:0]); end
`endif
      checks++;
      if (rdData[0][15:8] !== 8'h62) begin failures++; $display("[TB] FAIL bypass_other_port got=%h exp=62", rdData[0][15:8]); end
      tick();
      wrEn[0] = 1'b0;
      #1;
      checks++;
      if (rdData[0][7:0] !== 8'h3C) begin failures++; $display("[TB] FAIL bypass_after got=%h exp=3c", rdData[0][7:0]); end
      writeWord(1, 3'd5, 8'h44);
      wrEn[1] = 1'b1; wrAddr[1] = 3'd7; wrData[1] = 8'h99;
      setRd(1, 0, 3'd7);
      setRd(1, 1, 3'd5);
      #1;
      checks++;
      if (rdData[1] !== {8'h44, 8'h00}) begin failures++; $display("[TB] FAIL d6_oob_same_cycle got=%h exp=4400", rdData[1]); end
      tick();
      wrEn[1] = 1'b1; wrAddr[1] = 3'd6; wrData[1] = 8'h66;
      tick();
      wrEn[1] = 1'b0;
      setRd(1, 1, 3'd6);
      #1;
      checks++;
      if (rdData[1] !== 16'h0000) begin failures++; $display("[TB] FAIL d6_oob_discarded got=%h exp=0000", rdData[1]); end
   endtask

   task automatic test_random();
      logic [7:0] e;
      idleInputs();
      for (int c = 0; c < 400; c++) begin
         rst = ($urandom_range(0, 59) == 0);
         for (int k = 0; k < 2; k++) begin
            wrEn[k]     = $urandom_range(0, 1) == 1;
            wrAddr[k]   = AW'($urandom_range(0, 7));
            wrData[k]   = 8'($urandom);
            clearReq[k] = ($urandom_range(0, 19) == 0);
            rdAddr[k]   = (NR*AW)'($urandom);
         end
         if (($urandom_range(0, 3) == 0)) rdAddr[0][AW-1:0] = wrAddr[0];
         if (($urandom_range(0, 3) == 0)) rdAddr[1][AW-1:0] = wrAddr[1];
         #1;
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (busy[k] !== (clrLeft[k] > 0) || wrReady[k] !== (clrLeft[k] == 0) || clearDone[k] !== (clrLeft[k] == 1)) begin
               failures++;
               $display("[TB] FAIL rand_ctrl inst=%0d cycle=%0d got busy=%b ready=%b done=%b exp left=%0d", k, c, busy[k], wrReady[k], clearDone[k], clrLeft[k]);
            end
            for (int p = 0; p < NR; p++) begin
               e = expRead(k, rdAddr[k][p*AW +: AW]);
               checks++;
               if (rdData[k][p*DW +: DW] !== e) begin
                  failures++;
                  $display("[TB] FAIL rand_read inst=%0d port=%0d cycle=%0d got=%h exp=%h", k, p, c, rdData[k][p*DW +: DW], e);
               end
            end
         end
         tick();
      end
      idleInputs();
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         clrLeft[k] = 0;
         clrPtr[k]  = 0;
         for (int a = 0; a < 8; a++) model[k][a] = 8'h00;
      end
      idleInputs();
      @(negedge clk);
      test_reset();
      test_write_read();
      test_addr_zero();
      test_bulk_clear();
      test_clear_with_write();
      test_reset_mid_clear();
      test_back_to_back();
      test_bypass();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule
